exh_stim_resp_compactor: RTL and testbench

- Self-contained exhaustive stimulus sequencer and response compactor for the trojan-detection benchmarks.
- Sits directly upstream of a benchmark DUT (drives its N inputs) and directly downstream of it (samples its single-bit output).
- On each run it walks all 2^N_IN input vectors in ascending binary order and records the response per vector in a bit map.
- It folds every applied vector and its response into a MISR signature and compares that signature with a golden value, giving an in-hardware version of the per-vector dump the simulation flow writes to text files.

---
 rtl/exh_tb_pkg.sv | 29 ++
 rtl/exh_stim_resp_compactor_misr_reg.sv | 39 +++
 rtl/exh_stim_resp_compactor.sv | 147 ++++++++++++++
 tb/tb_exh_stim_resp_compactor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/exh_tb_pkg.sv
// Shared types, default MISR constants and the MISR step function used by the
// compactor RTL and by its reference model.
package exh_tb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    // One MISR step on a register of 'width' bits (1..32), carried in a 32-bit
    // container so one function serves every SIG_W. Bits above 'width' are zero.
    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [31:0] data,
                                              input logic [31:0] poly,
                                              input int unsigned width);
        logic [31:0] top_bit;
        logic [31:0] mask;
        logic [31:0] fb;
        top_bit = 32'd1 << (width - 1);
        mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb      = ((sig & top_bit) != 32'd0) ? poly : 32'd0;
        return ((sig << 1) ^ fb ^ data) & mask;
    endfunction

endpackage

// File: rtl/exh_stim_resp_compactor_misr_reg.sv
// Multiple-input signature register: shifts with polynomial feedback and folds
// in one data word per enabled cycle.
module misr_reg
    import exh_tb_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // next signature value for an enabled cycle
    always_comb begin
        sig_d = SIG_W'(misr_step(32'(sig_q), 32'(data), 32'(POLY), SIG_W));
    end

    // signature register: seed on reset or clear, step when enabled
    always_ff @(posedge CK) begin
        if (!reset) begin
            sig_q <= SEED;
        end else if (clear) begin
            sig_q <= SEED;
        end else if (enable) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/exh_stim_resp_compactor.sv
// Exhaustive stimulus sequencer and response compactor.
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// APPLY  | driving vector idx, counting down settle cycles, sampling at zero
// FINISH | one-cycle done pulse, signature compared with captured golden
module exh_stim_resp_compactor
    import exh_tb_pkg::*;
#(
    parameter int               N_IN   = 3,
    parameter int               N_OUT  = 1,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED)
) (
    input  logic                          CK,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [SIG_W-1:0]              golden_sig,
    output logic [N_IN-1:0]               stim_out,
    output logic                          stim_valid,
    input  logic [N_OUT-1:0]              resp_in,
    output logic                          busy,
    output logic                          done,
    output logic [SIG_W-1:0]              signature,
    output logic                          pass,
    output logic                          aborted,
    output logic [(2**N_IN)*N_OUT-1:0]    response_map
);

    localparam int              NV       = 2 ** N_IN;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [N_IN-1:0]         idx_q, idx_d;
    logic [NV*N_OUT-1:0]     map_q, map_d;
    logic [SIG_W-1:0]        golden_q, golden_d;
    logic                    pass_q, pass_d;
    logic                    aborted_q, aborted_d;
    logic                    misr_clear, misr_en;
    logic                    sig_match;
    logic [SIG_W-1:0]        misr_data;

    assign sig_match = (signature == golden_q);
    assign misr_data = SIG_W'({idx_q, resp_in});

    // next-state, counter, index and response-map update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        map_d      = map_q;
        golden_d   = golden_q;
        pass_d     = pass_q;
        aborted_d  = aborted_q;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = APPLY;
                    cnt_d      = SETTLE_C;
                    idx_d      = '0;
                    map_d      = '0;
                    golden_d   = golden_sig;
                    pass_d     = 1'b0;
                    aborted_d  = 1'b0;
                    misr_clear = 1'b1;
                end
            end
            APPLY: begin
                // abort beats a coinciding sample edge: the vector is not recorded
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    misr_en = 1'b1;
                    for (int i = 0; i < NV; i++) begin
                        if (idx_q == N_IN'(i)) begin
                            map_d[i*N_OUT +: N_OUT] = resp_in;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = SETTLE_C;
                    end
                end
            end
            FINISH: begin
                pass_d  = sig_match;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge CK) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            map_q     <= '0;
            golden_q  <= '0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            map_q     <= map_d;
            golden_q  <= golden_d;
            pass_q    <= pass_d;
            aborted_q <= aborted_d;
        end
    end

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .CK     (CK),
        .reset  (reset),
        .clear  (misr_clear),
        .enable (misr_en),
        .data   (misr_data),
        .sig    (signature)
    );

    assign busy         = (state_q == APPLY);
    assign stim_valid   = (state_q == APPLY);
    assign done         = (state_q == FINISH);
    // pass is visible alongside done, then held by pass_q until the next start
    assign pass         = pass_q | ((state_q == FINISH) & sig_match);
    assign stim_out     = idx_q;
    assign aborted      = aborted_q;
    assign response_map = map_q;

endmodule

// File: tb/tb_exh_stim_resp_compactor.sv
// Bench for the exhaustive stimulus/response compactor. Two instances run side
// by side (SETTLE=1 and SETTLE=0), each feeding its stim_out into a truth-table
// DUT model. Expectations come from cycle arithmetic and a per-vector MISR fold.
module tb_exh_stim_resp_compactor;
    import exh_tb_pkg::*;

    localparam int NV = 8;

    logic        CK = 1'b0;
    logic        reset, start, abort;
    logic [15:0] golden_sig;
    logic [7:0]  tt;

    logic [2:0]  stim_a, stim_b;
    logic        sv_a, sv_b, busy_a, busy_b, done_a, done_b;
    logic        pass_a, pass_b, ab_a, ab_b, resp_a, resp_b;
    logic [15:0] sig_a, sig_b;
    logic [7:0]  map_a, map_b;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    assign resp_a = tt[stim_a];
    assign resp_b = tt[stim_b];

    exh_stim_resp_compactor #(.SETTLE(1)) dut_a (
        .CK(CK), .reset(reset), .start(start), .abort(abort), .golden_sig(golden_sig),
        .stim_out(stim_a), .stim_valid(sv_a), .resp_in(resp_a), .busy(busy_a),
        .done(done_a), .signature(sig_a), .pass(pass_a), .aborted(ab_a),
        .response_map(map_a)
    );

    exh_stim_resp_compactor #(.SETTLE(0)) dut_b (
        .CK(CK), .reset(reset), .start(start), .abort(abort), .golden_sig(golden_sig),
        .stim_out(stim_b), .stim_valid(sv_b), .resp_in(resp_b), .busy(busy_b),
        .done(done_b), .signature(sig_b), .pass(pass_b), .aborted(ab_b),
        .response_map(map_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // vectors recorded before an abort at cycle a (0 = no abort)
    function automatic int nsamp(input int s, input int a);
        int n;
        n = 0;
        for (int i = 0; i < NV; i++) begin
            if (a == 0 || (i + 1) * (s + 1) < a) n++;
        end
        return n;
    endfunction

    function automatic logic [15:0] model_sig(input logic [7:0] t, input int n);
        logic [15:0] s;
        logic [2:0]  v;
        s = DEF_SEED;
        for (int i = 0; i < n; i++) begin
            v = i[2:0];
            s = 16'(misr_step(32'(s), 32'({v, t[i]}), 32'(DEF_POLY), 16));
        end
        return s;
    endfunction

    function automatic logic [7:0] model_map(input logic [7:0] t, input int n);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = t[i];
        return m;
    endfunction

    task automatic check_cycle(input string nm, input int s, input int c, input int a,
                               input logic [15:0] esig, input logic [15:0] gold,
                               input logic bz, input logic sv, input logic [2:0] so,
                               input logic dn, input logic ps, input logic ab);
        int  len, last_busy;
        bit  abt, eb;
        len       = NV * (s + 1);
        abt       = (a > 0) && (a <= len);
        last_busy = abt ? a : len;
        eb        = (c >= 1) && (c <= last_busy);
        chk($sformatf("%s.busy@%0d", nm, c), 32'(bz), 32'(eb));
        chk($sformatf("%s.valid@%0d", nm, c), 32'(sv), 32'(eb));
        if (eb) chk($sformatf("%s.stim@%0d", nm, c), 32'(so), 32'((c - 1) / (s + 1)));
        chk($sformatf("%s.done@%0d", nm, c), 32'(dn), 32'(!abt && c == len + 1));
        chk($sformatf("%s.aborted@%0d", nm, c), 32'(ab), 32'(abt && c > a));
        chk($sformatf("%s.pass@%0d", nm, c), 32'(ps),
            32'(!abt && c >= len + 1 && esig == gold));
    endtask

    // start in cycle 0, optional abort in cycle a, optional extra start (with a
    // different golden) in cycle r; checks every cycle up to 19
    task automatic run(input logic [15:0] gold, input int a, input int r);
        logic [15:0] esa, esb;
        int na, nb;
        na  = nsamp(1, a);
        nb  = nsamp(0, a);
        esa = model_sig(tt, na);
        esb = model_sig(tt, nb);
        @(negedge CK);
        golden_sig = gold;
        start      = 1'b1;
        abort      = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge CK);
            start      = (c == r);
            golden_sig = (c == r) ? ~gold : gold;
            abort      = (c == a);
            check_cycle("a", 1, c, a, esa, gold, busy_a, sv_a, stim_a, done_a, pass_a, ab_a);
            check_cycle("b", 0, c, a, esb, gold, busy_b, sv_b, stim_b, done_b, pass_b, ab_b);
        end
        start = 1'b0;
        abort = 1'b0;
        chk("a.map", 32'(map_a), 32'(model_map(tt, na)));
        chk("b.map", 32'(map_b), 32'(model_map(tt, nb)));
        chk("a.sig", 32'(sig_a), 32'(esa));
        chk("b.sig", 32'(sig_b), 32'(esb));
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, ".busy"},  32'({busy_a, busy_b}), 32'd0);
        chk({nm, ".valid"}, 32'({sv_a, sv_b}), 32'd0);
        chk({nm, ".stim"},  32'({stim_a, stim_b}), 32'd0);
        chk({nm, ".done"},  32'({done_a, done_b}), 32'd0);
        chk({nm, ".pass"},  32'({pass_a, pass_b}), 32'd0);
        chk({nm, ".abrt"},  32'({ab_a, ab_b}), 32'd0);
        chk({nm, ".map"},   32'({map_a, map_b}), 32'd0);
        chk({nm, ".sig_a"}, 32'(sig_a), 32'(DEF_SEED));
        chk({nm, ".sig_b"}, 32'(sig_b), 32'(DEF_SEED));
    endtask

    initial begin
        logic [15:0] gsig;
        logic [2:0]  v;
        int          a;

        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        golden_sig = 16'h1234;
        for (int i = 0; i < NV; i++) begin
            v     = i[2:0];
            tt[i] = ^v;
        end
        repeat (3) @(negedge CK);
        check_reset_state("rst");
        reset = 1'b1;

        // parity DUT, arbitrary golden
        run(16'h0000, 0, 0);
        chk("parity.map", 32'(map_a), 32'h96);

        // golden set to the fault-free signature
        gsig = model_sig(tt, NV);
        run(gsig, 0, 0);
        chk("golden.pass", 32'({pass_a, pass_b}), 32'b11);

        // trojan flips the response for vector 5
        tt[5] = ~tt[5];
        run(gsig, 0, 0);
        chk("trojan.map", 32'(map_a), 32'hB6);
        chk("trojan.pass", 32'({pass_a, pass_b}), 32'b00);
        tt[5] = ~tt[5];

        // abort while vector 2 is active on the SETTLE=1 instance
        run(gsig, 6, 0);
        chk("abort.map", 32'(map_a), 32'h02);

        // start during a run is ignored, golden untouched
        run(gsig, 0, 4);

        // reset in cycle 9 of a run
        @(negedge CK);
        golden_sig = gsig;
        start      = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge CK);
            start = 1'b0;
            if (c == 9) reset = 1'b0;
        end
        @(negedge CK);
        reset = 1'b1;
        check_reset_state("midrst");

        run(gsig, 0, 0);
        chk("fresh.map", 32'(map_a), 32'h96);
        chk("fresh.pass", 32'(pass_a), 32'd1);

        // random truth tables, goldens and abort points
        for (int k = 0; k < 8; k++) begin
            tt   = 8'($urandom);
            gsig = ($urandom_range(0, 1) == 1) ? model_sig(tt, NV) : 16'($urandom);
            a    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 18)) : 0;
            run(gsig, a, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
